// File: rtl/boot_mode_sequencer.sv
// Boot mode sequencer: debounced start button, CPU/programmer reset control and write steering.
// Optional PROG_STATS_EN macro enables the download word counter (otherwise word_count is 0).
//
// state | meaning
// HOLD  | CPU held in reset for RESET_HOLD_CYCLES, programmer disabled
// RUN   | CPU running, waiting for an accepted start_pg press
// PROG  | UART download active, CPU held in reset, programmer enabled

module boot_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 50000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_done,
    input  logic        upg_wen,
    input  logic [14:0] upg_adr,
    output logic        upg_rst,
    output logic        cpu_rst,
    output logic        rom_wen,
    output logic        ram_wen,
    output logic        prog_active,
    output logic        prog_error,
    output logic [15:0] word_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PROG = 2'd2
    } state_t;

    state_t          state       = ST_HOLD;
    state_t          next_state;
    logic [1:0]      sync_ff     = 2'b00;
    logic [DW-1:0]   deb_cnt     = '0;
    logic            sp_deb_q    = 1'b0;
    logic [HW-1:0]   hold_cnt    = '0;
    logic [TW-1:0]   to_cnt      = '0;
    logic            cpu_rst_q   = 1'b1;
    logic            upg_rst_q   = 1'b1;
    logic            prog_act_q  = 1'b0;
    logic            prog_err_q  = 1'b0;

    logic            sp_s;
    logic            sp_deb;
    logic            sp_acc;
    logic            timeout;
    logic            prog_entry;
    logic            timeout_abort;
    logic            unused_adr;

    assign sp_s    = sync_ff[1];
    assign sp_deb  = (deb_cnt == DEB_MAX);
    assign sp_acc  = sp_deb & ~sp_deb_q;
    assign timeout = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_MAX);

    always_ff @(posedge clock) begin
        if (rst) begin
            sync_ff  <= 2'b00;
            deb_cnt  <= '0;
            sp_deb_q <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], start_pg};
            if (!sp_s)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + 1'b1;
            sp_deb_q <= sp_deb;
        end
    end

    always_comb begin
        next_state    = state;
        prog_entry    = 1'b0;
        timeout_abort = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST)
                    next_state = ST_RUN;
            end
            ST_RUN: begin
                if (sp_acc) begin
                    next_state = ST_PROG;
                    prog_entry = 1'b1;
                end
            end
            ST_PROG: begin
                // upg_done wins over a coincident timeout, so no error is flagged
                if (upg_done) begin
                    next_state = ST_HOLD;
                end else if (timeout) begin
                    next_state    = ST_HOLD;
                    timeout_abort = 1'b1;
                end
            end
            default: next_state = ST_HOLD;
        endcase
        if (rst) begin
            next_state    = ST_HOLD;
            prog_entry    = 1'b0;
            timeout_abort = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        state <= next_state;

        if (rst || state != ST_HOLD || next_state != ST_HOLD)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 1'b1;

        if (rst || prog_entry || state != ST_PROG || upg_wen)
            to_cnt <= '0;
        else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;

        // rst deliberately leaves prog_error alone so the abort stays visible
        if (prog_entry)
            prog_err_q <= 1'b0;
        else if (timeout_abort)
            prog_err_q <= 1'b1;

        cpu_rst_q  <= (next_state != ST_RUN);
        upg_rst_q  <= (next_state != ST_PROG);
        prog_act_q <= (next_state == ST_PROG);
    end

    assign cpu_rst     = cpu_rst_q;
    assign upg_rst     = upg_rst_q;
    assign prog_active = prog_act_q;
    assign prog_error  = prog_err_q;

    assign rom_wen = upg_wen & ~upg_adr[14] & prog_act_q;
    assign ram_wen = upg_wen &  upg_adr[14] & prog_act_q;

    assign unused_adr = ^upg_adr[13:0];

`ifdef PROG_STATS_EN
    logic [15:0] wc_q = 16'h0000;

    always_ff @(posedge clock) begin
        if (prog_entry)
            wc_q <= 16'h0000;
        else if ((rom_wen | ram_wen) && wc_q != 16'hFFFF)
            wc_q <= wc_q + 16'h0001;
    end

    assign word_count = wc_q;
`else
    assign word_count = 16'h0000;
`endif

endmodule

// File: tb/tb_boot_mode_sequencer.sv
// Directed bench for boot_mode_sequencer: reset hold, debounce, write steering, timeout, mid-download rst.
// Expected word_count follows the PROG_STATS_EN build option.

module tb_boot_mode_sequencer;

    localparam int DEB = 8;
    localparam int RHC = 16;
    localparam int TMO = 100;

`ifdef PROG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start_pg = 1'b0;
    logic        upg_done = 1'b0;
    logic        upg_wen = 1'b0;
    logic [14:0] upg_adr = 15'h0;
    logic        upg_rst;
    logic        cpu_rst;
    logic        rom_wen;
    logic        ram_wen;
    logic        prog_active;
    logic        prog_error;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    boot_mode_sequencer #(
        .DEBOUNCE_CYCLES   (DEB),
        .RESET_HOLD_CYCLES (RHC),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start_pg    (start_pg),
        .upg_done    (upg_done),
        .upg_wen     (upg_wen),
        .upg_adr     (upg_adr),
        .upg_rst     (upg_rst),
        .cpu_rst     (cpu_rst),
        .rom_wen     (rom_wen),
        .ram_wen     (ram_wen),
        .prog_active (prog_active),
        .prog_error  (prog_error),
        .word_count  (word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // call right after the edge that entered HOLD; returns ticks until cpu_rst low
    task automatic hold_len(output int n, output logic upg_seen_low);
        n = 0;
        upg_seen_low = 1'b0;
        while (cpu_rst === 1'b1 && n < 100) begin
            tick();
            n++;
            if (upg_rst !== 1'b1 || prog_active !== 1'b0) upg_seen_low = 1'b1;
        end
    endtask

    task automatic enter_prog(input string tag);
        int lat;
        lat = 0;
        start_pg = 1'b1;
        while (prog_active !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        start_pg = 1'b0;
        check(tag, prog_active, 1'b1);
    endtask

    initial begin
        int   n;
        int   lat;
        logic bad;
        logic seen;

        repeat (3) tick();
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_upg_rst", upg_rst, 1'b1);
        check("rst_prog_active", prog_active, 1'b0);
        check("rst_wen", {rom_wen, ram_wen}, 2'b00);
        check("rst_prog_error", prog_error, 1'b0);
        check("rst_word_count", word_count, 16'h0);

        rst = 1'b0;
        hold_len(n, bad);
        check("hold_after_rst", n, RHC);
        check("hold_upg_rst_high", bad, 1'b0);

        seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            start_pg = 1'b1;
            repeat (5) begin tick(); seen |= prog_active; end
            start_pg = 1'b0;
            repeat (6) begin tick(); seen |= prog_active; end
        end
        check("short_pulses_ignored", seen, 1'b0);

        start_pg = 1'b1;
        lat = 0;
        while (prog_active !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        check("deb_latency_ok", (lat >= DEB + 1 && lat <= DEB + 3), 1'b1);
        check("prog_upg_rst", upg_rst, 1'b0);
        check("prog_cpu_rst", cpu_rst, 1'b1);
        bad = 1'b0;
        for (int i = lat; i < 20; i++) begin
            tick();
            if (prog_active !== 1'b1) bad = 1'b1;
        end
        start_pg = 1'b0;
        check("held_single_entry", bad, 1'b0);

        upg_adr = 15'h0004;
        upg_wen = 1'b1;
        #1;
        check("rom_write", {rom_wen, ram_wen}, 2'b10);
        tick();
        upg_adr = 15'h4004;
        #1;
        check("ram_write", {rom_wen, ram_wen}, 2'b01);
        tick();
        upg_wen = 1'b0;
        #1;
        check("wen_idle", {rom_wen, ram_wen}, 2'b00);
        tick();
        check("word_count_2", word_count, STATS ? 16'd2 : 16'd0);

        upg_done = 1'b1;
        tick();
        upg_done = 1'b0;
        check("done_to_hold", {prog_active, cpu_rst, upg_rst}, 3'b011);
        hold_len(n, bad);
        check("hold_after_done", n, RHC);
        check("done_no_error", prog_error, 1'b0);

        enter_prog("enter_timeout");
        n = 0;
        while (prog_active === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("timeout_len_ok", (n >= TMO && n <= TMO + 1), 1'b1);
        check("timeout_error", prog_error, 1'b1);
        hold_len(n, bad);
        check("hold_after_timeout", n, RHC);

        enter_prog("enter_after_timeout");
        check("error_cleared_on_entry", prog_error, 1'b0);
        upg_adr = 15'h0001;
        upg_wen = 1'b1;
        tick();
        upg_wen = 1'b0;
        upg_done = 1'b1;
        tick();
        upg_done = 1'b0;
        hold_len(n, bad);
        check("success_error_low", prog_error, 1'b0);
        check("success_word_count", word_count, STATS ? 16'd1 : 16'd0);

        upg_adr = 15'h0010;
        upg_wen = 1'b1;
        #1;
        check("run_write_discard", {rom_wen, ram_wen}, 2'b00);
        upg_adr = 15'h4010;
        #1;
        check("run_ram_discard", {rom_wen, ram_wen}, 2'b00);
        upg_wen = 1'b0;
        tick();

        enter_prog("enter_rst_mid");
        upg_wen = 1'b1;
        upg_adr = 15'h0001; tick();
        upg_adr = 15'h0002; tick();
        upg_adr = 15'h4003; tick();
        upg_wen = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_state", {prog_active, cpu_rst, upg_rst}, 3'b011);
        check("rst_mid_word_count", word_count, STATS ? 16'd3 : 16'd0);
        upg_wen = 1'b1;
        upg_adr = 15'h0005;
        #1;
        check("rst_mid_wen", {rom_wen, ram_wen}, 2'b00);
        upg_wen = 1'b0;
        rst = 1'b0;
        hold_len(n, bad);
        check("hold_after_rst_mid", n, RHC);

        enter_prog("enter_tie");
        repeat (TMO) tick();
        check("tie_still_prog", prog_active, 1'b1);
        upg_done = 1'b1;
        tick();
        upg_done = 1'b0;
        check("tie_to_hold", prog_active, 1'b0);
        check("tie_no_error", prog_error, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
